// File: rtl/addsub_pkg.sv
// Shared encodings for the add/subtract accumulator stage: command opcodes and FSM states.
package addsub_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned ST_W  = 2;
  localparam int unsigned DEF_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_accum_ctrl_if.sv
// Command and result handshake bundle between operand source, accumulator and monitor.
interface addsub_accum_ctrl_if
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_W
);

  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc;
  logic             c_flag;
  logic             z_flag;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, acc, c_flag, z_flag
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, acc, c_flag, z_flag
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational unsigned add/subtract; the top result bit is carry (add) or borrow (sub).
module addsub_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   res
);

  assign res = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});

endmodule

// File: rtl/addsub_accum_ctrl.sv
// Handshaked accumulator: IDLE accepts a command, EXEC applies it, HOLD presents the result.
// Define ADDSUB_SAT_EN for saturating ADD/SUB instead of modulo wrap-around.
module addsub_accum_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  addsub_accum_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;

  logic [WIDTH:0]   core_res;
  logic [WIDTH-1:0] res_acc;
  logic             res_c;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a   (acc_q),
    .b   (data_q),
    .sub (op_q == OP_SUB),
    .res (core_res)
  );

  // Result of the captured command against the current accumulator
  always_comb begin
    res_acc = '0;
    res_c   = 1'b0;
    unique case (op_q)
      OP_CLR:  ;
      OP_LOAD: res_acc = data_q;
      OP_ADD,
      OP_SUB:  {res_c, res_acc} = core_res;
      default: ;
    endcase
`ifdef ADDSUB_SAT_EN
    if (res_c) begin
      res_acc = (op_q == OP_ADD) ? {WIDTH{1'b1}} : '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CLR;
      data_q  <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          data_d  = bus.in_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        acc_d   = res_acc;
        c_d     = res_c;
        z_d     = (res_acc == '0);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is gated by rst so no command is offered while reset is asserted
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.acc       = acc_q;
  assign bus.c_flag    = c_q;
  assign bus.z_flag    = z_q;

endmodule
